// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - opcodes, ALU ops, mux selects and state encoding for the multicycle controller
package multicycle_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h05;
  localparam logic [5:0] OP_ORI  = 6'h06;
  localparam logic [5:0] OP_LW   = 6'h07;
  localparam logic [5:0] OP_SW   = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h09;
  localparam logic [5:0] OP_J    = 6'h0A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUREG = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_MEM_LD,
    S_WB_MEM,
    S_MEM_ST,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

endpackage

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle CPU datapath
// Optional MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN: undefined opcodes halt and raise sticky illegal_op.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                halted,
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic [3:0]          state_dbg
);

  state_t     state, next_state;
  logic [3:0] exec_alu, dec_alu, alu_sel;
  logic       unused_alu_zero;

  // The datapath gates PCWriteCond with alu_zero, so the flag never reaches this FSM.
  assign unused_alu_zero = alu_zero;

`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
  logic dec_illegal, illegal_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      exec_alu <= ALU_ADD;
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state <= next_state;
      // Execute-stage ALU op is captured at decode so later opcode changes are ignored.
      if (state == S_DECODE) exec_alu <= dec_alu;
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
      if (state == S_DECODE && dec_illegal) illegal_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    next_state = state;
    dec_alu    = ALU_ADD;
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
    dec_illegal = 1'b0;
`endif
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPCODE_W'(OP_NOP):  next_state = S_FETCH;
          OPCODE_W'(OP_ADD):  next_state = S_EXEC_R;
          OPCODE_W'(OP_SUB):  begin next_state = S_EXEC_R; dec_alu = ALU_SUB; end
          OPCODE_W'(OP_AND):  begin next_state = S_EXEC_R; dec_alu = ALU_AND; end
          OPCODE_W'(OP_OR):   begin next_state = S_EXEC_R; dec_alu = ALU_OR;  end
          OPCODE_W'(OP_ADDI): next_state = S_EXEC_I;
          OPCODE_W'(OP_ORI):  begin next_state = S_EXEC_I; dec_alu = ALU_OR;  end
          OPCODE_W'(OP_LW):   next_state = S_MEM_LD;
          OPCODE_W'(OP_SW):   next_state = S_MEM_ST;
          OPCODE_W'(OP_BEQ):  next_state = S_BRANCH;
          OPCODE_W'(OP_J):    next_state = S_JUMP;
          OPCODE_W'(OP_HALT): next_state = S_HALT;
          default: begin
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
            next_state  = S_HALT;
            dec_illegal = 1'b1;
`else
            next_state  = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R: next_state = S_WB_ALU;
      S_EXEC_I: next_state = S_WB_ALU;
      S_WB_ALU: next_state = S_FETCH;
      S_MEM_LD: next_state = S_WB_MEM;
      S_WB_MEM: next_state = S_FETCH;
      S_MEM_ST: next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  // Output decode; reset blanks every line so an abandoned instruction issues no writes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REGB;
    alu_sel     = ALU_ADD;
    halted      = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ALUSrcB = SRCB_ONE;
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          MemRead = 1'b1;
        end
        S_DECODE: ALUSrcB = SRCB_SEXT;
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          alu_sel = exec_alu;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = (exec_alu == ALU_OR) ? SRCB_ZEXT : SRCB_SEXT;
          alu_sel = exec_alu;
        end
        S_WB_ALU: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_MEM_LD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_ST: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          alu_sel     = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUREG;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign ALUOp     = ALUOP_W'(alu_sel);
  assign state_dbg = reset ? 4'd0 : state;
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_q & ~reset;
`endif

endmodule
